// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant, operand capture, registered result.
// Latency: grant edge N -> EXEC in cycle N+1 -> rsp_valid in cycle N+2; initiation interval 3 cycles minimum.
// Backpressure: the result is held in RESP until rsp_ready[id]; no new request is accepted while busy.
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_op1,
  input  logic [NUM_REQ*XLEN-1:0] req_op2,
  input  logic [NUM_REQ*3-1:0]    req_opcode,
  input  logic [NUM_REQ-1:0]      req_signed,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]         rsp_data,
  output logic [XLEN-1:0]         alu_operand1,
  output logic [XLEN-1:0]         alu_operand2,
  output logic [2:0]              alu_opcode,
  output logic                    alu_is_signed,
  input  logic [XLEN-1:0]         alu_res,
  output logic                    busy
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cap_id;

  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   scan_idx;
  logic [IDW-1:0]   next_rr;
  logic [NUM_REQ-1:0] cap_onehot;

  // Round-robin search starting at rr_ptr; first pending requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  // Pointer moves past the winner so it goes to the back of the line.
  always_comb begin
    next_rr = IDW'((int'(grant_id) + 1) % NUM_REQ);
  end

  // Grant is only offered in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // One-hot of the captured requester, used to flag the response.
  always_comb begin
    cap_onehot         = '0;
    cap_onehot[cap_id] = 1'b1;
  end

  // Main FSM; the ALU inputs are the capture registers themselves, cleared on return to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cap_id        <= '0;
      alu_operand1  <= '0;
      alu_operand2  <= '0;
      alu_opcode    <= '0;
      alu_is_signed <= 1'b0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            alu_operand1  <= req_op1[grant_id*XLEN +: XLEN];
            alu_operand2  <= req_op2[grant_id*XLEN +: XLEN];
            alu_opcode    <= req_opcode[grant_id*3 +: 3];
            alu_is_signed <= req_signed[grant_id];
            cap_id        <= grant_id;
            rr_ptr        <= next_rr;
            busy          <= 1'b1;
            state         <= EXEC;
          end
        end
        EXEC: begin
          // ALU has had a full cycle on stable captured inputs.
          rsp_data  <= alu_res;
          rsp_valid <= cap_onehot;
          state     <= RESP;
        end
        RESP: begin
          // Only the owning requester's ready releases the result.
          if (rsp_ready[cap_id]) begin
            rsp_data      <= '0;
            rsp_valid     <= '0;
            alu_operand1  <= '0;
            alu_operand2  <= '0;
            alu_opcode    <= '0;
            alu_is_signed <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU.
// Latency: checks are placed on the exact cycles of grant, execute and response.
// Backpressure: holds rsp_ready low and drives wrong-id ready to confirm the result is held.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_op1;
  logic [63:0] req_op2;
  logic [5:0]  req_opcode;
  logic [1:0]  req_signed;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] alu_operand1;
  logic [31:0] alu_operand2;
  logic [2:0]  alu_opcode;
  logic        alu_is_signed;
  logic [31:0] alu_res;
  logic        busy;

  int total;
  int bad;

  alu_share_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_opcode   (req_opcode),
    .req_signed   (req_signed),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_opcode   (alu_opcode),
    .alu_is_signed(alu_is_signed),
    .alu_res      (alu_res),
    .busy         (busy)
  );

  // Behavioural ALU sitting on the arbiter's ALU port.
  always_comb begin
    alu_res = '0;
    case (alu_opcode)
      3'd0: alu_res = alu_operand1 + alu_operand2;
      3'd1: alu_res = alu_operand1 - alu_operand2;
      3'd2: alu_res = alu_operand1 & alu_operand2;
      3'd3: alu_res = alu_operand1 | alu_operand2;
      3'd4: alu_res = alu_operand1 ^ alu_operand2;
      3'd5: alu_res = alu_is_signed ? {31'd0, $signed(alu_operand1) < $signed(alu_operand2)}
                                    : {31'd0, alu_operand1 < alu_operand2};
      3'd6: alu_res = alu_operand1 << alu_operand2[4:0];
      default: alu_res = alu_is_signed ? ($signed(alu_operand1) >>> alu_operand2[4:0])
                                       : (alu_operand1 >> alu_operand2[4:0]);
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] opc, input logic s);
    req_op1[i*32 +: 32] = a;
    req_op2[i*32 +: 32] = b;
    req_opcode[i*3 +: 3] = opc;
    req_signed[i]        = s;
  endtask

  logic [31:0] rr_data [2];

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    rsp_ready  = 2'b00;
    req_op1    = '0;
    req_op2    = '0;
    req_opcode = '0;
    req_signed = '0;
    rr_data[0] = 32'd7;
    rr_data[1] = 32'h30;

    // Reset held three cycles with requests pending.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_op1", alu_operand1, 32'd0);
    check("rst_op2", alu_operand2, 32'd0);
    check("rst_opc", {29'd0, alu_opcode}, 32'd0);
    check("rst_sgn", {31'd0, alu_is_signed}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    req_valid = 2'b00;
    rst_n     = 1'b1;

    // Single request from requester 0: 5 + 7.
    @(negedge clk);
    set_req(0, 32'd5, 32'd7, 3'd0, 1'b0);
    req_valid = 2'b01;
    #1;
    check("single_grant", {30'd0, req_ready}, 32'd1);
    check("single_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    set_req(0, 32'hDEAD_BEEF, 32'h1234_5678, 3'd4, 1'b1);
    #1;
    check("single_exec_ready", {30'd0, req_ready}, 32'd0);
    check("single_exec_busy", {31'd0, busy}, 32'd1);
    check("single_exec_op1", alu_operand1, 32'd5);
    check("single_exec_op2", alu_operand2, 32'd7);
    check("single_exec_rspv", {30'd0, rsp_valid}, 32'd0);
    @(negedge clk); #1;
    check("single_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    check("single_rsp_data", rsp_data, 32'd12);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    check("single_done_rspv", {30'd0, rsp_valid}, 32'd0);
    check("single_done_busy", {31'd0, busy}, 32'd0);
    check("single_done_data", rsp_data, 32'd0);
    check("single_done_op1", alu_operand1, 32'd0);

    // Reset again so the pointer starts at 0, then round robin with both valid.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 32'd10, 32'd3, 3'd1, 1'b0);
    set_req(1, 32'hF0, 32'h3C, 3'd2, 1'b0);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1;
      check("rr_grant", {30'd0, req_ready}, (g % 2 == 1) ? 32'd2 : 32'd1);
      @(negedge clk);
      @(negedge clk); #1;
      check("rr_rsp_valid", {30'd0, rsp_valid}, (g % 2 == 1) ? 32'd2 : 32'd1);
      check("rr_rsp_data", rsp_data, rr_data[g % 2]);
      @(negedge clk);
    end

    // Backpressure: requester 0 (0x0F00 | 0x00F0) held for five cycles.
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    set_req(0, 32'h0F00, 32'h00F0, 3'd3, 1'b0);
    #1;
    check("bp_grant", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b11;
    set_req(1, 32'hFFFF_FFFF, 32'd1, 3'd5, 1'b1);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data", rsp_data, 32'h0FF0);
      check("bp_op1", alu_operand1, 32'h0F00);
      check("bp_opc", {29'd0, alu_opcode}, 32'd3);
      check("bp_req_ready", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    check("bp_next_grant", {30'd0, req_ready}, 32'd2);

    // Requester 1: signed set-less-than of -1 < 1.
    @(negedge clk);
    req_valid = 2'b01;
    set_req(0, 32'hAAAA_5555, 32'hFFFF_0000, 3'd4, 1'b0);
    #1;
    check("slt_sgn", {31'd0, alu_is_signed}, 32'd1);
    check("slt_opc", {29'd0, alu_opcode}, 32'd5);
    @(negedge clk); #1;
    check("slt_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    check("slt_rsp_data", rsp_data, 32'd1);
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    check("wid_grant", {30'd0, req_ready}, 32'd1);

    // Wrong-id ready must not release requester 0's result.
    @(negedge clk);
    @(negedge clk);
    rsp_ready = 2'b10;
    #1;
    check("wid_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    check("wid_rsp_data", rsp_data, 32'h5555_5555);
    @(negedge clk); #1;
    check("wid_hold_valid", {30'd0, rsp_valid}, 32'd1);
    check("wid_hold_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;
    check("wid_hold2_valid", {30'd0, rsp_valid}, 32'd1);
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    set_req(1, 32'd1, 32'd2, 3'd0, 1'b0);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    check("mid_idle_busy", {31'd0, busy}, 32'd0);
    check("mid_grant", {30'd0, req_ready}, 32'd2);

    // Reset during EXEC aborts the operation.
    @(negedge clk);
    req_valid = 2'b00;
    rst_n     = 1'b0;
    #1;
    check("mid_exec_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rspv", {30'd0, rsp_valid}, 32'd0);
    check("mid_rst_op1", alu_operand1, 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("mid_no_rsp", {30'd0, rsp_valid}, 32'd0);
      check("mid_no_busy", {31'd0, busy}, 32'd0);
    end
    req_valid = 2'b11;
    #1;
    check("mid_rr_reset", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
